// File: rtl/ccg_pattern_engine_if.sv
// ccg_pattern_engine_if: run control, stimulus/response and result bundle of the pattern engine
interface ccg_pattern_engine_if #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 28,
  parameter int CNT_W = 16
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] num_patterns;
  logic [IN_W-1:0]  seed;
  logic [IN_W-1:0]  dut_in;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] signature;
  logic [CNT_W-1:0] pattern_cnt;
  modport master (
    output start, abort, num_patterns, seed, dut_out,
    input  dut_in, busy, done, signature, pattern_cnt
  );
  modport slave (
    input  start, abort, num_patterns, seed, dut_out,
    output dut_in, busy, done, signature, pattern_cnt
  );
endinterface

// File: rtl/ccg_pattern_engine.sv
// ccg_pattern_engine: LFSR stimulus generator and MISR response compactor for a combinational circuit under test
module ccg_pattern_engine #(
  parameter int IN_W  = 21,
  parameter int OUT_W = 28,
  parameter int CNT_W = 16,
  parameter int LAT   = 0
) (
  input logic               clk,
  input logic               rst_n,
  ccg_pattern_engine_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;
  state_t           state, state_nx;
  logic [CNT_W-1:0] rem, cnt;
  logic [IN_W-1:0]  seed_q, lfsr, lfsr_nx, lfsr_init, din;
  logic [OUT_W-1:0] sig, sig_nx;
  logic             busy, go, run, last, kill, absorb;
  assign busy      = state == LOAD || state == RUN || state == DRAIN;
  assign go        = (state == IDLE || state == DONE) && bus.start && !bus.abort;
  assign run       = state == RUN;
  assign last      = rem == CNT_W'(1);
  assign kill      = busy && bus.abort;
  assign lfsr_nx   = {lfsr[IN_W-2:0], lfsr[IN_W-1] ^ lfsr[IN_W-3]};
  assign lfsr_init = seed_q == '0 ? IN_W'(1) : seed_q;
  assign sig_nx    = {sig[OUT_W-2:0], sig[OUT_W-1] ^ sig[OUT_W-4]} ^ bus.dut_out;
  always_comb begin
    state_nx = kill ? IDLE
             : go ? LOAD
             : state == LOAD ? (rem == '0 ? DONE : RUN)
             : run && last ? (LAT > 0 ? DRAIN : DONE)
             : state == DRAIN && last ? DONE
             : state;
  end
  // rem counts remaining RUN patterns, then is reused for the DRAIN length
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rem    <= '0;
      cnt    <= '0;
      seed_q <= '0;
      lfsr   <= '0;
      din    <= '0;
      sig    <= '0;
    end else begin
      state <= state_nx;
      if (go) begin
        rem    <= bus.num_patterns;
        seed_q <= bus.seed;
      end else if (run && last) rem <= CNT_W'(LAT);
      else if (run || state == DRAIN) rem <= rem - 1'b1;
      if (state == LOAD) begin
        lfsr <= lfsr_init;
        din  <= lfsr_init;
        sig  <= '0;
        cnt  <= '0;
      end else begin
        if (run) begin
          lfsr <= lfsr_nx;
          din  <= lfsr_nx;
        end
        if (absorb) begin
          sig <= sig_nx;
          cnt <= cnt + 1'b1;
        end
      end
    end
  end
  // valid tags follow each presented pattern until its response arrives
  if (LAT == 0) begin : g_nopipe
    assign absorb = run;
  end else begin : g_pipe
    logic [LAT-1:0] vp;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) vp <= '0;
      else vp <= kill ? '0 : LAT'({vp, run});
    end
    assign absorb = vp[LAT-1];
  end
  assign bus.dut_in      = din;
  assign bus.busy        = busy;
  assign bus.done        = state == DONE;
  assign bus.signature   = sig;
  assign bus.pattern_cnt = cnt;
endmodule

// File: tb/tb_ccg_pattern_engine.sv
// tb_ccg_pattern_engine: directed checks of a LAT=0 and a LAT=2 engine driven in lockstep
module tb_ccg_pattern_engine;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] num;
  logic [20:0] seed;
  int          mode;
  int          n_chk = 0, n_err = 0;
  int          ca, cb;
  logic [20:0] seq_a [8];
  logic [27:0] d1, d2, ref_sig, exp_sig;
  logic [20:0] exp_x;

  always #5 clk = ~clk;

  ccg_pattern_engine_if #(.IN_W(21), .OUT_W(28), .CNT_W(16)) a ();
  ccg_pattern_engine_if #(.IN_W(21), .OUT_W(28), .CNT_W(16)) b ();

  ccg_pattern_engine #(.IN_W(21), .OUT_W(28), .CNT_W(16), .LAT(0)) u_a (.clk(clk), .rst_n(rst_n), .bus(a));
  ccg_pattern_engine #(.IN_W(21), .OUT_W(28), .CNT_W(16), .LAT(2)) u_b (.clk(clk), .rst_n(rst_n), .bus(b));

  function automatic logic [27:0] resp(input logic [20:0] x, input int m);
    return m == 0 ? {7'd0, x} : m == 1 ? 28'h1 : {x[6:0] ^ x[20:14], x};
  endfunction

  assign a.start = start;
  assign b.start = start;
  assign a.abort = abort;
  assign b.abort = abort;
  assign a.num_patterns = num;
  assign b.num_patterns = num;
  assign a.seed = seed;
  assign b.seed = seed;
  assign a.dut_out = resp(a.dut_in, mode);
  assign b.dut_out = d2;

  always @(posedge clk) begin
    d1 <= resp(b.dut_in, mode);
    d2 <= d1;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [20:0] s, input int n, input int m,
                       output logic [27:0] sg, output logic [20:0] x);
    x  = s == '0 ? 21'h1 : s;
    sg = '0;
    for (int i = 0; i < n; i++) begin
      sg = {sg[26:0], sg[27] ^ sg[24]} ^ resp(x, m);
      x  = {x[19:0], x[20] ^ x[18]};
    end
  endtask

  task automatic run(input logic [15:0] n, input logic [20:0] s, input int abort_at, input int start_at);
    int cyc;
    cyc   = 0;
    num   = n;
    seed  = s;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    ca = 0;
    cb = 0;
    while ((a.busy || b.busy) && cyc < 70000) begin
      if (cyc < 8) seq_a[cyc] = a.dut_in;
      ca += int'(a.busy);
      cb += int'(b.busy);
      abort = cyc == abort_at;
      start = cyc == start_at;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      cyc++;
    end
    check("run_timeout", 64'(cyc >= 70000), 0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_din_a"}, a.dut_in, 0);
    check({tag, "_sig_a"}, a.signature, 0);
    check({tag, "_cnt_a"}, a.pattern_cnt, 0);
    check({tag, "_busy_a"}, a.busy, 0);
    check({tag, "_done_a"}, a.done, 0);
    check({tag, "_din_b"}, b.dut_in, 0);
    check({tag, "_sig_b"}, b.signature, 0);
    check({tag, "_busy_b"}, b.busy, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    mode  = 0;
    num   = '0;
    seed  = '0;
    #12 check_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    check("idle_abort_busy", a.busy, 0);
    check("idle_abort_done", a.done, 0);

    // seed 0 becomes 1; zero-extended responses 1,2,4 fold to 4
    run(16'd3, 21'h0, -1, -1);
    check("seq1", seq_a[1], 21'h000001);
    check("seq2", seq_a[2], 21'h000002);
    check("seq3", seq_a[3], 21'h000004);
    check("busy_a_n3", ca, 4);
    check("busy_b_n3", cb, 6);
    check("done_a_n3", a.done, 1);
    check("cnt_a_n3", a.pattern_cnt, 3);
    check("cnt_b_n3", b.pattern_cnt, 3);
    check("sig_a_n3", a.signature, 28'h4);
    check("sig_b_n3", b.signature, 28'h4);

    mode = 1;
    run(16'd2, 21'h12345, -1, -1);
    check("sig_a_const2", a.signature, 28'h3);
    check("sig_b_const2", b.signature, 28'h3);
    run(16'd1, 21'h12345, -1, -1);
    check("sig_a_const1", a.signature, 28'h1);
    check("sig_b_const1", b.signature, 28'h1);

    run(16'd0, 21'h7, -1, -1);
    check("busy_a_n0", ca, 1);
    check("busy_b_n0", cb, 1);
    check("done_a_n0", a.done, 1);
    check("done_b_n0", b.done, 1);
    check("sig_a_n0", a.signature, 0);
    check("cnt_a_n0", a.pattern_cnt, 0);

    mode = 2;
    model(21'h1ABCD, 10, 2, exp_sig, exp_x);
    run(16'd10, 21'h1ABCD, -1, 4);
    ref_sig = a.signature;
    check("busy_a_n10", ca, 11);
    check("busy_b_n10", cb, 13);
    check("sig_a_n10", a.signature, exp_sig);
    check("sig_b_n10", b.signature, exp_sig);
    check("cnt_b_n10", b.pattern_cnt, 10);
    repeat (3) @(posedge clk);
    #1;
    check("hold_done", a.done, 1);
    check("hold_sig_b", b.signature, exp_sig);
    check("hold_cnt_a", a.pattern_cnt, 10);
    check("hold_din_a", a.dut_in, exp_x);
    check("hold_din_b", b.dut_in, exp_x);

    model(21'h1ABCD, 2, 2, exp_sig, exp_x);
    run(16'd10, 21'h1ABCD, 2, 1);
    check("abort_busy", ca, 3);
    check("abort_done_a", a.done, 0);
    check("abort_done_b", b.done, 0);
    check("abort_cnt_a", a.pattern_cnt, 2);
    check("abort_cnt_b", b.pattern_cnt, 0);
    check("abort_sig_a", a.signature, exp_sig);

    num   = 16'd10;
    seed  = 21'h1ABCD;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_zero("midrst");
    @(posedge clk); #1 rst_n = 1'b1;
    run(16'd10, 21'h1ABCD, -1, -1);
    check("rerun_sig_a", a.signature, ref_sig);
    check("rerun_sig_b", b.signature, ref_sig);

    model(21'h155555, 65535, 2, exp_sig, exp_x);
    run(16'hFFFF, 21'h155555, -1, -1);
    check("max_done", a.done, 1);
    check("max_cnt_a", a.pattern_cnt, 16'hFFFF);
    check("max_cnt_b", b.pattern_cnt, 16'hFFFF);
    check("max_sig_a", a.signature, exp_sig);
    check("max_sig_b", b.signature, exp_sig);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
